// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and word-memory port bundle of the load/store unit.
// master = pipeline plus data memory, slave = load_store_unit.
interface load_store_unit_if;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        fault;
   logic        busy;
   logic [31:0] mem_address;
   logic [31:0] mem_writeData;
   logic        mem_memWrite;
   logic        mem_memRead;
   logic [31:0] mem_readData;

   modport master (
      output req, op, addr, wdata, mem_readData,
      input  rdata, done, fault, busy,
      input  mem_address, mem_writeData, mem_memWrite, mem_memRead
   );

   modport slave (
      input  req, op, addr, wdata, mem_readData,
      output rdata, done, fault, busy,
      output mem_address, mem_writeData, mem_memWrite, mem_memRead
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word memory; done in cycle 1 (fault), 2 (load/SW), 3 (SH/SB).
// busy holds the pipeline while an access is in flight; req is ignored until busy drops.
module load_store_unit #(
   parameter int DEPTH = 256
) (
   input logic              clk,
   input logic              reset_n,
   load_store_unit_if.slave bus
);
   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SB  = 3'b111;

   typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        done_q;
   logic        fault_q;

   logic        is_word;
   logic        is_half;
   logic        misaligned;
   logic        out_of_range;

   function automatic logic [31:0] load_extend(logic [2:0] o, logic [1:0] lane, logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = w[{lane[1], 4'b0000} +: 16];
      case (o)
         OP_LW:   load_extend = w;
         OP_LH:   load_extend = {{16{h[15]}}, h};
         OP_LHU:  load_extend = {16'h0000, h};
         OP_LB:   load_extend = {{24{b[7]}}, b};
         default: load_extend = {24'h000000, b};
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(logic [31:0] w, logic [2:0] o, logic [1:0] lane,
                                              logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (o == OP_SB) r[{lane, 3'b000} +: 8] = d[7:0];
      else            r[{lane[1], 4'b0000} +: 16] = d[15:0];
      return r;
   endfunction

   always_comb begin
      is_word      = (bus.op == OP_LW) || (bus.op == OP_SW);
      is_half      = (bus.op == OP_LH) || (bus.op == OP_LHU) || (bus.op == OP_SH);
      misaligned   = (is_word && (bus.addr[1:0] != 2'b00)) || (is_half && bus.addr[0]);
      out_of_range = {2'b00, bus.addr[31:2]} >= 32'(DEPTH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         op_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  op_q    <= bus.op;
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  if (misaligned || out_of_range) begin
                     done_q  <= 1'b1;
                     fault_q <= 1'b1;
                  end else if (bus.op == OP_SW) begin
                     state <= STORE;
                  end else if (bus.op == OP_SH || bus.op == OP_SB) begin
                     state <= RMW_RD;
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               rdata_q <= load_extend(op_q, addr_q[1:0], bus.mem_readData);
               done_q  <= 1'b1;
               state   <= IDLE;
            end
            RMW_RD: begin
               merge_q <= bus.mem_readData;
               state   <= RMW_WR;
            end
            default: begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Memory port is a pure decode of the state, so reset drops every strobe immediately.
   always_comb begin
      bus.mem_address   = (state != IDLE) ? {2'b00, addr_q[31:2]} : 32'h0;
      bus.mem_memRead   = (state == LOAD) || (state == RMW_RD);
      bus.mem_memWrite  = (state == STORE) || (state == RMW_WR);
      bus.mem_writeData = 32'h0;
      if (state == STORE)
         bus.mem_writeData = wdata_q;
      else if (state == RMW_WR)
         bus.mem_writeData = lane_merge(merge_q, op_q, addr_q[1:0], wdata_q);
   end

   assign bus.busy  = (state != IDLE);
   assign bus.rdata = rdata_q;
   assign bus.done  = done_q;
   assign bus.fault = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256-word data memory.
module tb_load_store_unit;
   logic clk;
   logic reset_n;
   int   total;
   int   bad;
   int   wr_cnt;
   int   lat;
   logic [31:0] mem [256];

   load_store_unit_if bus ();

   load_store_unit #(.DEPTH(256)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_readData = mem[bus.mem_address[7:0]];

   always @(posedge clk) begin
      if (bus.mem_memWrite) begin
         mem[bus.mem_address[7:0]] <= bus.mem_writeData;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and returns the cycle in which done rose (capped at 10).
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        output int l);
      bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = w;
      tick();
      bus.req = 1'b0;
      l = 1;
      while (!bus.done && l < 10) begin
         tick();
         l++;
      end
   endtask

   initial begin
      int wr_before;
      total = 0; bad = 0; wr_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.req = 1'b0; bus.op = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
      reset_n = 1'b0;
      tick(); tick();
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_done",  {31'b0, bus.done}, 32'h0);
      chk("rst_fault", {31'b0, bus.fault}, 32'h0);
      chk("rst_busy",  {31'b0, bus.busy}, 32'h0);
      chk("rst_maddr", bus.mem_address, 32'h0);
      chk("rst_mwr",   {31'b0, bus.mem_memWrite}, 32'h0);
      chk("rst_mrd",   {31'b0, bus.mem_memRead}, 32'h0);
      chk("rst_mwdat", bus.mem_writeData, 32'h0);
      reset_n = 1'b1;
      tick();

      // SW 0x10 then LW 0x10 issued in the SW done cycle
      bus.req = 1'b1; bus.op = 3'b101; bus.addr = 32'h10; bus.wdata = 32'hDEADBEEF;
      tick();
      bus.req = 1'b0;
      chk("sw_c1_addr",  bus.mem_address, 32'h4);
      chk("sw_c1_wr",    {31'b0, bus.mem_memWrite}, 32'h1);
      chk("sw_c1_wdat",  bus.mem_writeData, 32'hDEADBEEF);
      chk("sw_c1_busy",  {31'b0, bus.busy}, 32'h1);
      tick();
      chk("sw_c2_done",  {31'b0, bus.done}, 32'h1);
      chk("sw_c2_fault", {31'b0, bus.fault}, 32'h0);
      chk("sw_c2_wr",    {31'b0, bus.mem_memWrite}, 32'h0);
      chk("sw_wr_cnt",   wr_cnt, 32'd1);
      bus.req = 1'b1; bus.op = 3'b000; bus.addr = 32'h10;
      tick();
      chk("b2b_c1_rd",   {31'b0, bus.mem_memRead}, 32'h1);
      chk("b2b_c1_addr", bus.mem_address, 32'h4);
      // a request raised while busy must be ignored
      bus.op = 3'b101; bus.addr = 32'h20; bus.wdata = 32'h12345678;
      tick();
      bus.req = 1'b0;
      chk("b2b_c2_done", {31'b0, bus.done}, 32'h1);
      chk("lw_rdata",    bus.rdata, 32'hDEADBEEF);
      tick();
      chk("ign_busy",    {31'b0, bus.busy}, 32'h0);
      tick();
      chk("ign_wr_cnt",  wr_cnt, 32'd1);
      chk("ign_mem8",    mem[8], 32'h0);

      // SB 0x13 over 0x11223344
      mem[4] = 32'h11223344;
      bus.req = 1'b1; bus.op = 3'b111; bus.addr = 32'h13; bus.wdata = 32'h000000AA;
      tick();
      bus.req = 1'b0;
      chk("sb_c1_rd",   {31'b0, bus.mem_memRead}, 32'h1);
      chk("sb_c1_wr",   {31'b0, bus.mem_memWrite}, 32'h0);
      tick();
      chk("sb_c2_wr",   {31'b0, bus.mem_memWrite}, 32'h1);
      chk("sb_c2_wdat", bus.mem_writeData, 32'hAA223344);
      chk("sb_c2_done", {31'b0, bus.done}, 32'h0);
      tick();
      chk("sb_c3_done", {31'b0, bus.done}, 32'h1);
      chk("sb_mem",     mem[4], 32'hAA223344);
      issue(3'b011, 32'h13, 32'h0, lat);
      chk("lb_lat",   lat, 32'd2);
      chk("lb_rdata", bus.rdata, 32'hFFFFFFAA);
      issue(3'b100, 32'h13, 32'h0, lat);
      chk("lbu_rdata", bus.rdata, 32'h000000AA);
      issue(3'b011, 32'h10, 32'h0, lat);
      chk("lb0_rdata", bus.rdata, 32'h00000044);

      // SH 0x12 over 0x11223344
      mem[4] = 32'h11223344;
      issue(3'b110, 32'h12, 32'h00008001, lat);
      chk("sh_lat", lat, 32'd3);
      chk("sh_mem", mem[4], 32'h80013344);
      issue(3'b001, 32'h12, 32'h0, lat);
      chk("lh_rdata", bus.rdata, 32'hFFFF8001);
      issue(3'b010, 32'h12, 32'h0, lat);
      chk("lhu_rdata", bus.rdata, 32'h00008001);
      issue(3'b010, 32'h10, 32'h0, lat);
      chk("lhu_lo_rdata", bus.rdata, 32'h00003344);

      // faults: misaligned word, misaligned half, out of range
      wr_before = wr_cnt;
      issue(3'b000, 32'h11, 32'h0, lat);
      chk("f_lw_lat",   lat, 32'd1);
      chk("f_lw_fault", {31'b0, bus.fault}, 32'h1);
      chk("f_lw_rdata", bus.rdata, 32'h00003344);
      issue(3'b110, 32'h13, 32'h0000BEEF, lat);
      chk("f_sh_lat",   lat, 32'd1);
      chk("f_sh_fault", {31'b0, bus.fault}, 32'h1);
      issue(3'b101, 32'h400, 32'hCAFEF00D, lat);
      chk("f_sw_lat",   lat, 32'd1);
      chk("f_sw_fault", {31'b0, bus.fault}, 32'h1);
      tick();
      chk("f_fault_pulse", {31'b0, bus.fault}, 32'h0);
      chk("f_wr_cnt", wr_cnt, wr_before);
      chk("f_mem4",   mem[4], 32'h80013344);
      chk("f_mem0",   mem[0], 32'h0);

      // reset during RMW_RD of an SB aborts the write
      wr_before = wr_cnt;
      bus.req = 1'b1; bus.op = 3'b111; bus.addr = 32'h10; bus.wdata = 32'h00000055;
      tick();
      bus.req = 1'b0;
      chk("ra_c1_rd", {31'b0, bus.mem_memRead}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("ra_busy",  {31'b0, bus.busy}, 32'h0);
      chk("ra_rd",    {31'b0, bus.mem_memRead}, 32'h0);
      chk("ra_wr",    {31'b0, bus.mem_memWrite}, 32'h0);
      chk("ra_addr",  bus.mem_address, 32'h0);
      chk("ra_rdata", bus.rdata, 32'h0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("ra_wr_cnt", wr_cnt, wr_before);
      issue(3'b000, 32'h10, 32'h0, lat);
      chk("ra_lw_lat",   lat, 32'd2);
      chk("ra_lw_rdata", bus.rdata, 32'h80013344);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting between the MEM pipeline stage and the word-addressed data memory `dataMem`. It turns byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB requests into word accesses: address-to-word-index conversion, byte-lane merging for sub-word stores (read-modify-write), and sign/zero extension for sub-word loads. It flags misaligned and out-of-range accesses and stalls the pipeline through `busy` while an access is in flight.

## Interface
- `DEPTH`, 256, number of 32-bit words in the attached data memory; word index ≥ DEPTH is out of range.
- `clk`  in  1  rising-edge clock, shared with `dataMem`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, sampled only while `busy`=0.
- `op`  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; SH uses [15:0], SB uses [7:0].
- `rdata`  out  32  extended load result, registered, valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  high with `done` when the access was rejected.
- `busy`  out  1  access in flight; pipeline holds while high.
- `mem_address`  out  32  word index to `dataMem`.
- `mem_writeData`  out  32  word to `dataMem`.
- `mem_memWrite`  out  1  write strobe; `dataMem` commits on the `clk` edge.
- `mem_memRead`  out  1  read qualifier.
- `mem_readData`  in  32  combinational read word from `dataMem`.

## Operation
- Little-endian lanes: byte k = `addr[1:0]` occupies bits [8k+7:8k]. Halfword at `addr[1]` occupies [16·addr[1]+15 : 16·addr[1]].
- Word index = `{2'b00, addr[31:2]}`.
- Fault conditions, checked at acceptance:
  - word ops with `addr[1:0]`≠0;
  - half ops with `addr[0]`=1;
  - word index ≥ DEPTH.
- A faulted access causes no memory read or write.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR.
  - IDLE: `req`=1 latches `op`, `addr`, `wdata`.
  - Fault: stays IDLE and registers `done`=`fault`=1.
  - LW/LH/LHU/LB/LBU go to LOAD. SW goes to STORE. SH/SB go to RMW_RD.
- LOAD:
  - drives `mem_address`, `mem_memRead`=1;
  - at the edge, selects the lane from `mem_readData`, extends it (LH/LB sign, LHU/LBU zero, LW whole) into `rdata`, sets `done` → IDLE.
- STORE: drives `mem_memWrite`=1, `mem_writeData`=`wdata`; at the edge sets `done` → IDLE.
- RMW_RD: `mem_memRead`=1; at the edge captures `mem_readData` into an internal merge register → RMW_WR.
- RMW_WR:
  - `mem_memWrite`=1; `mem_writeData` = merge register with the addressed lane replaced by `wdata` low bits;
  - at the edge sets `done` → IDLE.
- `busy` = (state ≠ IDLE). `req` during `busy` is ignored; the pipeline holds it.
- In IDLE, `mem_address`, `mem_writeData`, `mem_memRead` and `mem_memWrite` are 0.
- `rdata` holds its last load value. Stores and faults do not modify it.

## Timing
- Request accepted at the edge ending cycle 0.
- Latencies (cycle in which `done`=1):
  - Fault: cycle 1.
  - Load: memory access in cycle 1, `done` in cycle 2.
  - SW: write strobe in cycle 1, `done` in cycle 2.
  - SH/SB: read in cycle 1, write in cycle 2, `done` in cycle 3.
- `done` is high exactly one cycle, in IDLE. A new `req` in the same cycle is accepted, giving back-to-back operation.
- `mem_memWrite` is high for exactly one cycle per store; never for loads or faults.
- Reset (any time, asynchronous):
  - state IDLE;
  - `rdata`, `done`, `fault`, `busy`, and all `mem_*` outputs = 0;
  - merge register cleared.
- Reset during RMW_RD aborts the store with no write. Reset during STORE/RMW_WR before the edge also suppresses the write.
- Memory contents are never cleared by this block.

## Test plan
- Reset, then SW 0x10, 0xDEADBEEF → cycle 1 `mem_address`=4, `mem_memWrite`=1; `done` in cycle 2. Then LW 0x10 → `rdata`=0xDEADBEEF.
- Word 4 preset 0x11223344; SB 0x13, `wdata`=0x000000AA → write 0xAA223344 in cycle 2. Then LB 0x13 → 0xFFFFFFAA; LBU 0x13 → 0x000000AA.
- SH 0x12, 0x8001 over 0x11223344 → 0x80013344. Then LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- LW 0x11, SH 0x13 and SW 0x400 (DEPTH=256) → `done`=`fault`=1 in cycle 1; `mem_memWrite` never asserted; memory unchanged.
- `reset_n` low during the RMW_RD cycle of an SB → no write, all outputs 0. After release, LW to the same word returns the old value.
- LW issued in the `done` cycle of the previous SW → accepted, `done` two cycles later. `req` toggled while `busy`=1 → ignored, with no extra memory strobe.
